word_typewriter: RTL and testbench

- Parametrised on-screen word renderer for the end, title and score screens.
- Stores a runtime-loaded string of letter codes and reveals it one letter at a time, typewriter style, paced in frames.
- After the reveal completes, optionally blinks the whole word.
- Sits between the VGA pixel-coordinate source and the letter bitmap ROM. It outputs a drawing request plus the letter code and glyph offsets for the current pixel.

---
 rtl/word_typewriter_if.sv | 33 +++
 rtl/word_typewriter.sv | 147 ++++++++++++++
 tb/tb_word_typewriter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/word_typewriter_if.sv
// Interface between a word_typewriter and whoever loads strings and feeds pixel coordinates.
// The master side drives strings, frame pulses and pixels; the slave side returns drawing info.
interface word_typewriter_if #(
    parameter int MAX_LETTERS   = 16,
    parameter int LETTER_W_LOG2 = 5,
    parameter int LETTER_H_LOG2 = 5
);
    localparam int LEN_W = $clog2(MAX_LETTERS + 1);

    logic                     start;
    logic [5*MAX_LETTERS-1:0] letters_in;
    logic [LEN_W-1:0]         length_in;
    logic                     clear;
    logic                     startOfFrame;
    logic [10:0]              pixelX;
    logic [10:0]              pixelY;
    logic                     drawingRequest;
    logic [4:0]               letterCode;
    logic [LETTER_W_LOG2-1:0] offsetX;
    logic [LETTER_H_LOG2-1:0] offsetY;
    logic                     busy;
    logic                     done;

    modport master (
        output start, letters_in, length_in, clear, startOfFrame, pixelX, pixelY,
        input  drawingRequest, letterCode, offsetX, offsetY, busy, done
    );

    modport slave (
        input  start, letters_in, length_in, clear, startOfFrame, pixelX, pixelY,
        output drawingRequest, letterCode, offsetX, offsetY, busy, done
    );
endinterface

// File: rtl/word_typewriter.sv
// Typewriter-style word renderer: reveals a loaded string one letter per REVEAL_FRAMES frames,
// optionally blinks it afterwards, and maps the current pixel to a glyph code plus offsets.
module word_typewriter #(
    parameter int MAX_LETTERS   = 16,
    parameter int TOP_LEFT_X    = 10,
    parameter int TOP_LEFT_Y    = 50,
    parameter int LETTER_W_LOG2 = 5,
    parameter int LETTER_H_LOG2 = 5,
    parameter int REVEAL_FRAMES = 4,
    parameter int BLINK_EN      = 1,
    parameter int BLINK_FRAMES  = 30
) (
    input logic               clk,
    input logic               reset,
    word_typewriter_if.slave  bus
);
    localparam int LEN_W   = $clog2(MAX_LETTERS + 1);
    localparam int IDX_W   = (MAX_LETTERS > 1) ? $clog2(MAX_LETTERS) : 1;
    localparam int CNT_TOP = (REVEAL_FRAMES > BLINK_FRAMES) ? REVEAL_FRAMES : BLINK_FRAMES;
    localparam int CNT_W   = $clog2(CNT_TOP + 1);

    localparam logic [4:0]  SPACE = 5'd26;
    localparam logic [10:0] X0    = 11'(TOP_LEFT_X);
    localparam logic [10:0] Y0    = 11'(TOP_LEFT_Y);
    localparam logic [11:0] Y_END = 12'(TOP_LEFT_Y + (2 ** LETTER_H_LOG2));

    typedef enum logic [1:0] {IDLE, TYPING, HOLD} state_t;

    state_t           state;
    logic [4:0]       letter_buf [MAX_LETTERS];
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] revealed;
    logic [CNT_W-1:0] cnt;
    logic             vis;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        return (l > LEN_W'(MAX_LETTERS)) ? LEN_W'(MAX_LETTERS) : l;
    endfunction

    logic [LEN_W-1:0] len_clamped;
    logic [LEN_W-1:0] rev_inc;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        len_clamped = clamp_len(bus.length_in);
        rev_inc     = revealed + 1'b1;
        cnt_inc     = cnt + 1'b1;
    end

    // clear beats start, and start beats a simultaneous frame pulse (that frame is dropped)
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            len      <= '0;
            revealed <= '0;
            cnt      <= '0;
            vis      <= 1'b1;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            for (int i = 0; i < MAX_LETTERS; i++) letter_buf[i] <= SPACE;
        end else if (bus.clear) begin
            state    <= IDLE;
            revealed <= '0;
            cnt      <= '0;
            vis      <= 1'b1;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else if (bus.start) begin
            for (int i = 0; i < MAX_LETTERS; i++) letter_buf[i] <= bus.letters_in[5*i +: 5];
            len      <= len_clamped;
            revealed <= '0;
            cnt      <= '0;
            vis      <= 1'b1;
            if (len_clamped == '0) begin
                state    <= HOLD;
                bus.busy <= 1'b0;
                bus.done <= 1'b1;
            end else begin
                state    <= TYPING;
                bus.busy <= 1'b1;
                bus.done <= 1'b0;
            end
        end else if (bus.startOfFrame) begin
            case (state)
                TYPING: begin
                    if (cnt_inc == CNT_W'(REVEAL_FRAMES)) begin
                        cnt      <= '0;
                        revealed <= rev_inc;
                        if (rev_inc == len) begin
                            state    <= HOLD;
                            vis      <= 1'b1;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                HOLD: begin
                    if (BLINK_EN != 0) begin
                        if (cnt_inc == CNT_W'(BLINK_FRAMES)) begin
                            cnt <= '0;
                            vis <= ~vis;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    logic [10:0]              rel_x_p0;
    logic [LETTER_H_LOG2-1:0] rel_y_p0;
    logic [10:0]              col_p0;
    logic [4:0]               code_p0;
    logic                     hit_p0;

    // p0: combinational hit test on the incoming pixel
    always_comb begin
        rel_x_p0 = bus.pixelX - X0;
        rel_y_p0 = LETTER_H_LOG2'(bus.pixelY - Y0);
        col_p0   = rel_x_p0 >> LETTER_W_LOG2;
        code_p0  = letter_buf[col_p0[IDX_W-1:0]];
        hit_p0   = (bus.pixelX >= X0) &&
                   (bus.pixelY >= Y0) && ({1'b0, bus.pixelY} < Y_END) &&
                   (col_p0 < 11'(revealed)) &&
                   (code_p0 != SPACE) &&
                   (state != IDLE) && vis;
    end

    // p1: registered drawing outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.drawingRequest <= 1'b0;
            bus.letterCode     <= '0;
            bus.offsetX        <= '0;
            bus.offsetY        <= '0;
        end else begin
            bus.drawingRequest <= hit_p0;
            bus.letterCode     <= hit_p0 ? code_p0 : '0;
            bus.offsetX        <= hit_p0 ? rel_x_p0[LETTER_W_LOG2-1:0] : '0;
            bus.offsetY        <= hit_p0 ? rel_y_p0 : '0;
        end
    end
endmodule

// File: tb/tb_word_typewriter.sv
// Directed bench for word_typewriter: reveal pacing, pixel mapping, blinking, clamping and clear/start priority.
module tb_word_typewriter;
    localparam int MAXL = 16;
    localparam int LW   = $clog2(MAXL + 1);

    logic clk;
    logic reset;

    word_typewriter_if #(.MAX_LETTERS(MAXL), .LETTER_W_LOG2(5), .LETTER_H_LOG2(5)) bus ();

    word_typewriter #(
        .MAX_LETTERS(MAXL), .TOP_LEFT_X(10), .TOP_LEFT_Y(50),
        .LETTER_W_LOG2(5), .LETTER_H_LOG2(5),
        .REVEAL_FRAMES(4), .BLINK_EN(1), .BLINK_FRAMES(30)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic frame();
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        tick();
    endtask

    task automatic probe(input string tag, input int x, input int y,
                         input logic dr, input int code, input int ox, input int oy);
        bus.pixelX = 11'(x);
        bus.pixelY = 11'(y);
        tick();
        chk({tag, ".dr"},   32'(bus.drawingRequest), 32'(dr));
        chk({tag, ".code"}, 32'(bus.letterCode),     32'(code));
        chk({tag, ".ox"},   32'(bus.offsetX),        32'(ox));
        chk({tag, ".oy"},   32'(bus.offsetY),        32'(oy));
    endtask

    task automatic do_start(input logic [5*MAXL-1:0] v, input int l);
        bus.letters_in = v;
        bus.length_in  = LW'(l);
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic b, input logic d);
        chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
        chk({tag, ".done"}, 32'(bus.done), 32'(d));
    endtask

    logic [5*MAXL-1:0] go_vec;
    logic [5*MAXL-1:0] abc_vec;
    int go_codes [9] = '{6, 0, 12, 4, 26, 14, 21, 4, 17};

    initial begin
        int bad_sweep;
        go_vec  = '0;
        abc_vec = '0;
        for (int i = 0; i < 9; i++) go_vec[5*i +: 5] = 5'(go_codes[i]);
        for (int i = 0; i < MAXL; i++) abc_vec[5*i +: 5] = 5'(i);

        bus.start = 1'b0; bus.clear = 1'b0; bus.startOfFrame = 1'b0;
        bus.letters_in = '0; bus.length_in = '0;
        bus.pixelX = '0; bus.pixelY = '0;
        reset = 1'b1;
        tick(3);
        chk_state("reset", 1'b0, 1'b0);
        chk("reset.dr", 32'(bus.drawingRequest), 32'd0);
        chk("reset.code", 32'(bus.letterCode), 32'd0);
        reset = 1'b0;
        tick();

        bad_sweep = 0;
        for (int y = 0; y < 120; y += 3) begin
            for (int x = 0; x < 700; x += 7) begin
                bus.pixelX = 11'(x);
                bus.pixelY = 11'(y);
                tick();
                if (bus.drawingRequest !== 1'b0) bad_sweep++;
            end
        end
        chk("idle_sweep_hits", 32'(bad_sweep), 32'd0);
        chk_state("idle", 1'b0, 1'b0);

        do_start(go_vec, 9);
        chk_state("go_start", 1'b1, 1'b0);
        probe("go_rev0", 15, 53, 1'b0, 0, 0, 0);
        for (int f = 1; f <= 36; f++) begin
            frame();
            chk_state($sformatf("go_f%0d", f), 1'(f >= 36 ? 0 : 1), 1'(f >= 36 ? 1 : 0));
            if (f == 4) begin
                probe("go_rev1_c0", 15, 53, 1'b1, 6, 5, 3);
                probe("go_rev1_c1", 10 + 32 + 5, 53, 1'b0, 0, 0, 0);
            end
        end
        probe("space", 10 + 4*32 + 5, 53, 1'b0, 0, 0, 0);
        probe("m_pix", 10 + 2*32 + 7, 59, 1'b1, 12, 7, 9);
        probe("left_of_x", 9, 53, 1'b0, 0, 0, 0);
        probe("col9", 10 + 9*32, 53, 1'b0, 0, 0, 0);
        probe("above_y", 15, 49, 1'b0, 0, 0, 0);
        probe("below_y", 15, 82, 1'b0, 0, 0, 0);
        probe("last_row", 15, 81, 1'b1, 6, 5, 31);
        probe("last_col", 10 + 8*32 + 31, 50, 1'b1, 17, 31, 0);

        for (int f = 1; f <= 61; f++) begin
            frame();
            if (((f / 30) % 2) == 0)
                probe($sformatf("blink_f%0d", f), 15, 53, 1'b1, 6, 5, 3);
            else
                probe($sformatf("blink_f%0d", f), 15, 53, 1'b0, 0, 0, 0);
        end

        do_start(abc_vec, 20);
        chk_state("clamp_start", 1'b1, 1'b0);
        frame(); frame(); frame(); frame();
        probe("clamp_c0", 15, 53, 1'b1, 0, 5, 3);
        for (int f = 5; f <= 64; f++) frame();
        chk_state("clamp_end", 1'b0, 1'b1);
        probe("clamp_c15", 10 + 15*32 + 3, 60, 1'b1, 15, 3, 10);
        probe("clamp_c16", 10 + 16*32 + 3, 60, 1'b0, 0, 0, 0);

        do_start(go_vec, 0);
        chk_state("len0", 1'b0, 1'b1);
        probe("len0_c0", 15, 53, 1'b0, 0, 0, 0);

        do_start(go_vec, 9);
        for (int f = 1; f <= 12; f++) frame();
        chk_state("rev3", 1'b1, 1'b0);
        probe("rev3_c2", 10 + 2*32 + 7, 59, 1'b1, 12, 7, 9);
        probe("rev3_c3", 10 + 3*32 + 7, 59, 1'b0, 0, 0, 0);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        chk_state("clear", 1'b0, 1'b0);
        probe("clear_c0", 15, 53, 1'b0, 0, 0, 0);
        do_start(go_vec, 9);
        chk_state("restart", 1'b1, 1'b0);
        probe("restart_c0", 15, 53, 1'b0, 0, 0, 0);
        frame(); frame(); frame(); frame();
        probe("restart_rev1_c0", 15, 53, 1'b1, 6, 5, 3);
        probe("restart_rev1_c1", 10 + 32 + 5, 53, 1'b0, 0, 0, 0);

        bus.clear = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.start = 1'b0;
        chk_state("clear_start", 1'b0, 1'b0);
        probe("clear_start_c0", 15, 53, 1'b0, 0, 0, 0);

        bus.letters_in   = go_vec;
        bus.length_in    = LW'(9);
        bus.start        = 1'b1;
        bus.startOfFrame = 1'b1;
        tick();
        bus.start        = 1'b0;
        bus.startOfFrame = 1'b0;
        chk_state("start_sof", 1'b1, 1'b0);
        frame(); frame(); frame();
        probe("start_sof_3f", 15, 53, 1'b0, 0, 0, 0);
        frame();
        probe("start_sof_4f", 15, 53, 1'b1, 6, 5, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
